exc_sequencer: RTL and testbench

Precise-exception sequencer sitting between the 4-stage pipeline (F, D, E, M) and CP0. Tracks exceptions raised in any stage as per-stage shadow records that advance with the pipeline. Commits only the oldest one when its instruction reaches M, and injects pending interrupts at M. Drives CP0's exception inputs for exactly one cycle, then sequences a pipeline flush.

---
 rtl/exc_sequencer.sv | 155 +++++++++++++++
 tb/tb_exc_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_sequencer.sv
// Precise-exception sequencer: per-stage shadow records, M-stage commit, CP0 strobe and flush.
// Optional interrupt injection at M is enabled by defining EXC_SEQ_INT_EN.
module exc_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         advance,
    input  logic [3:0]   stageValid,
    input  logic [3:0]   raise,
    input  logic [19:0]  raiseCause,
    input  logic [127:0] stagePC,
    input  logic [3:0]   stageBD,
    input  logic [31:0]  badVAddrF,
    input  logic [31:0]  badVAddrM,
    input  logic         interruptNow,
    output logic         killM,
    output logic         isException,
    output logic [4:0]   exceptionCause,
    output logic [31:0]  exceptionPC,
    output logic [31:0]  exceptionBadVAddr,
    output logic         isBD,
    output logic         hasExceptionInPipeline,
    output logic         flush
);
    localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StCommit = 2'd1;
    localparam logic [1:0] StFlush  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      rec_v_q, rec_v_d;
    logic [4:0]      rec_cause_q [4];
    logic [4:0]      rec_cause_d [4];
    logic [31:0]     rec_bva_q [4];
    logic [31:0]     rec_bva_d [4];

    logic [3:0]      eff_v;
    logic [4:0]      eff_cause [4];
    logic [31:0]     eff_bva [4];
    logic            idle, int_req, commit;

    logic [4:0]      cause_q;
    logic [31:0]     pc_q, bva_q;
    logic            bd_q;

    logic            unused_stage;
    assign unused_stage = ^{stagePC[95:0], stageBD[2:0]};

    assign idle = (state_q == StIdle);

    // A held record always beats a fresh raise: the oldest exception of an instruction wins.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            eff_v[s]     = rec_v_q[s] | (idle & raise[s] & stageValid[s]);
            eff_cause[s] = rec_v_q[s] ? rec_cause_q[s] : raiseCause[5*s +: 5];
            eff_bva[s]   = rec_bva_q[s];
            if (!rec_v_q[s]) begin
                eff_bva[s] = (s == 0) ? badVAddrF : ((s == 3) ? badVAddrM : 32'd0);
            end
        end
    end

`ifdef EXC_SEQ_INT_EN
    assign int_req = interruptNow & ~eff_v[3];
`else
    logic unused_int;
    assign unused_int = interruptNow;
    assign int_req    = 1'b0;
`endif

    assign commit                 = idle & stageValid[3] & (eff_v[3] | int_req);
    assign killM                  = commit;
    assign hasExceptionInPipeline = ~idle | (|eff_v);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rec_v_d = '0;
        for (int s = 0; s < 4; s++) begin
            rec_cause_d[s] = '0;
            rec_bva_d[s]   = '0;
        end
        case (state_q)
            StIdle: begin
                if (commit) begin
                    state_d = StCommit;
                end else if (advance) begin
                    for (int s = 1; s < 4; s++) begin
                        rec_v_d[s]     = eff_v[s-1];
                        rec_cause_d[s] = eff_cause[s-1];
                        rec_bva_d[s]   = eff_bva[s-1];
                    end
                end else begin
                    rec_v_d = eff_v;
                    for (int s = 0; s < 4; s++) begin
                        rec_cause_d[s] = eff_cause[s];
                        rec_bva_d[s]   = eff_bva[s];
                    end
                end
            end
            StCommit: begin
                state_d = StFlush;
                cnt_d   = CntW'(FLUSH_CYCLES - 1);
            end
            StFlush: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rec_v_q <= '0;
            for (int s = 0; s < 4; s++) begin
                rec_cause_q[s] <= '0;
                rec_bva_q[s]   <= '0;
            end
            cause_q <= '0;
            pc_q    <= '0;
            bva_q   <= '0;
            bd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rec_v_q <= rec_v_d;
            for (int s = 0; s < 4; s++) begin
                rec_cause_q[s] <= rec_cause_d[s];
                rec_bva_q[s]   <= rec_bva_d[s];
            end
            if (commit) begin
                cause_q <= eff_v[3] ? eff_cause[3] : 5'd0;
                bva_q   <= eff_v[3] ? eff_bva[3] : 32'd0;
                pc_q    <= stagePC[127:96];
                bd_q    <= stageBD[3];
            end
        end
    end

    assign isException       = (state_q == StCommit);
    assign flush             = ~idle;
    assign exceptionCause    = cause_q;
    assign exceptionPC       = pc_q;
    assign exceptionBadVAddr = bva_q;
    assign isBD              = bd_q;
endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: per-cycle compare against an instruction-level model,
// plus literal spot checks for each scenario.
module tb_exc_sequencer;
    localparam int FC = 2;
`ifdef EXC_SEQ_INT_EN
    localparam bit IntEn = 1'b1;
`else
    localparam bit IntEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, advance, interruptNow;
    logic [3:0]   stageValid, raise, stageBD;
    logic [19:0]  raiseCause;
    logic [127:0] stagePC;
    logic [31:0]  badVAddrF, badVAddrM;
    logic         killM, isException, isBD, hasExceptionInPipeline, flush;
    logic [4:0]   exceptionCause;
    logic [31:0]  exceptionPC, exceptionBadVAddr;

    logic [31:0]  p_pc [4];
    assign stagePC = {p_pc[3], p_pc[2], p_pc[1], p_pc[0]};

    exc_sequencer #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .advance(advance), .stageValid(stageValid),
        .raise(raise), .raiseCause(raiseCause), .stagePC(stagePC), .stageBD(stageBD),
        .badVAddrF(badVAddrF), .badVAddrM(badVAddrM), .interruptNow(interruptNow),
        .killM(killM), .isException(isException), .exceptionCause(exceptionCause),
        .exceptionPC(exceptionPC), .exceptionBadVAddr(exceptionBadVAddr), .isBD(isBD),
        .hasExceptionInPipeline(hasExceptionInPipeline), .flush(flush)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: first exception per in-flight instruction, plus cycles left in the commit/flush window.
    logic [3:0]  mv;
    logic [4:0]  mc [4];
    logic [31:0] mb [4];
    int          phase;
    logic [4:0]  e_cause;
    logic [31:0] e_pc, e_bva;
    logic        e_bd;
    logic [3:0]  ev;
    logic [4:0]  ec [4];
    logic [31:0] eb [4];
    logic        m_int, m_commit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic calc_eff();
        for (int s = 0; s < 4; s++) begin
            if (phase != 0) begin
                ev[s] = 1'b0; ec[s] = '0; eb[s] = '0;
            end else if (mv[s]) begin
                ev[s] = 1'b1; ec[s] = mc[s]; eb[s] = mb[s];
            end else begin
                ev[s] = raise[s] & stageValid[s];
                ec[s] = raiseCause[5*s +: 5];
                eb[s] = (s == 0) ? badVAddrF : ((s == 3) ? badVAddrM : 32'd0);
            end
        end
        m_int    = IntEn & interruptNow & ~ev[3];
        m_commit = (phase == 0) & stageValid[3] & (ev[3] | m_int);
    endtask

    task automatic compare();
        calc_eff();
        chk("killM", killM, m_commit);
        chk("hasExc", hasExceptionInPipeline, (phase != 0) | (|ev));
        chk("isException", isException, phase == FC + 1);
        chk("flush", flush, phase != 0);
        chk("cause", exceptionCause, e_cause);
        chk("pc", exceptionPC, e_pc);
        chk("badVAddr", exceptionBadVAddr, e_bva);
        chk("isBD", isBD, e_bd);
    endtask

    task automatic model_update(output bit did);
        did = 1'b0;
        if (reset) begin
            phase = 0; mv = '0;
            e_cause = '0; e_pc = '0; e_bva = '0; e_bd = 1'b0;
            return;
        end
        calc_eff();
        if (phase != 0) begin
            phase--;
            mv = '0;
        end else if (m_commit) begin
            did     = 1'b1;
            e_cause = ev[3] ? ec[3] : 5'd0;
            e_bva   = ev[3] ? eb[3] : 32'd0;
            e_pc    = p_pc[3];
            e_bd    = stageBD[3];
            phase   = FC + 1;
            mv      = '0;
        end else if (advance) begin
            for (int s = 3; s > 0; s--) begin
                mv[s] = ev[s-1]; mc[s] = ec[s-1]; mb[s] = eb[s-1];
            end
            mv[0] = 1'b0;
        end else begin
            for (int s = 0; s < 4; s++) begin
                mv[s] = ev[s]; mc[s] = ec[s]; mb[s] = eb[s];
            end
        end
    endtask

    task automatic tick();
        bit did;
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        model_update(did);
        if (advance) begin
            for (int s = 3; s > 0; s--) p_pc[s] = p_pc[s-1];
            stageValid = {stageValid[2:0], 1'b0};
            stageBD    = {stageBD[2:0], 1'b0};
        end
        if (did) stageValid = '0;
        raise = '0;
    endtask

    task automatic wait_idle();
        repeat (FC + 2) tick();
    endtask

    initial begin
        int fl;
        reset = 1'b1; advance = 1'b0; interruptNow = 1'b0;
        stageValid = '0; raise = '0; stageBD = '0; raiseCause = '0;
        badVAddrF = '0; badVAddrM = '0;
        for (int s = 0; s < 4; s++) p_pc[s] = '0;
        mv = '0; phase = 0;
        @(posedge clk);
        #1;
        begin
            bit d;
            model_update(d);
        end
        tick();
        reset = 1'b0;
        chk("rst_isException", isException, 0);
        chk("rst_flush", flush, 0);
        chk("rst_cause", exceptionCause, 0);
        chk("rst_pc", exceptionPC, 0);

        // F raise travels to M and commits there.
        advance = 1'b1;
        stageValid[0] = 1'b1; p_pc[0] = 32'h3000;
        raise[0] = 1'b1; raiseCause[4:0] = 5'd4; badVAddrF = 32'h3;
        tick(); tick(); tick();
        #1 chk("s1_killM", killM, 1);
        tick();
        chk("s1_isException", isException, 1);
        chk("s1_cause", exceptionCause, 4);
        chk("s1_pc", exceptionPC, 32'h3000);
        chk("s1_bva", exceptionBadVAddr, 32'h3);
        chk("s1_isBD", isBD, 0);
        fl = 0;
        for (int i = 0; i < 8; i++) begin
            if (flush) fl++;
            tick();
        end
        chk("s1_flush_len", fl, FC + 1);

        // D raise then E raise on the same instruction: D cause is kept.
        stageValid[0] = 1'b1; p_pc[0] = 32'h4000;
        tick();
        raise[1] = 1'b1; raiseCause[9:5] = 5'd10;
        tick();
        raise[2] = 1'b1; raiseCause[14:10] = 5'd12;
        tick();
        tick();
        chk("s2_isException", isException, 1);
        chk("s2_cause", exceptionCause, 10);
        chk("s2_pc", exceptionPC, 32'h4000);
        chk("s2_bva", exceptionBadVAddr, 0);
        wait_idle();

        // D raise held across a 5-cycle stall.
        stageValid[0] = 1'b1; p_pc[0] = 32'h5000;
        tick();
        advance = 1'b0;
        raise[1] = 1'b1; raiseCause[9:5] = 5'd10;
        tick();
        raiseCause[9:5] = 5'd3;
        repeat (4) tick();
        #1 chk("s3_hasExc", hasExceptionInPipeline, 1);
        advance = 1'b1;
        tick(); tick();
        #1 chk("s3_killM", killM, 1);
        tick();
        chk("s3_cause", exceptionCause, 10);
        chk("s3_pc", exceptionPC, 32'h5000);
        wait_idle();

        // Interrupt on a clean M instruction.
        advance = 1'b0;
        stageValid = 4'b1000; p_pc[3] = 32'h6000; interruptNow = 1'b1;
        #1 chk("s4_killM", killM, IntEn);
        tick();
        chk("s4_isException", isException, IntEn);
        chk("s4_cause", exceptionCause, IntEn ? 32'd0 : 32'd10);
        chk("s4_pc", exceptionPC, IntEn ? 32'h6000 : 32'h5000);
        interruptNow = 1'b0; stageValid = '0;
        wait_idle();

        // M raise beats a simultaneous interrupt; interrupt waits for the flush to end.
        stageValid = 4'b1000; p_pc[3] = 32'h7000; stageBD = 4'b1000;
        raise[3] = 1'b1; raiseCause[19:15] = 5'd12; badVAddrM = 32'h1234;
        interruptNow = 1'b1;
        tick();
        chk("s5_isException", isException, 1);
        chk("s5_cause", exceptionCause, 12);
        chk("s5_isBD", isBD, 1);
        chk("s5_bva", exceptionBadVAddr, 32'h1234);
        stageValid = 4'b1000; p_pc[3] = 32'h7004; stageBD = '0;
        for (int i = 0; i < FC + 1; i++) begin
            #1 chk("s5_defer_killM", killM, 0);
            tick();
        end
        #1 chk("s5_int_killM", killM, IntEn);
        tick();
        chk("s5_int_isException", isException, IntEn);
        chk("s5_int_pc", exceptionPC, IntEn ? 32'h7004 : 32'h7000);
        interruptNow = 1'b0; stageValid = '0;
        wait_idle();

        // Raise on a bubble is discarded.
        raise[2] = 1'b1;
        #1 chk("s6_bubble_hasExc", hasExceptionInPipeline, 0);
        advance = 1'b1;
        tick(); tick();
        #1 chk("s6_bubble_later", hasExceptionInPipeline, 0);
        tick();
        chk("s6_no_exc", isException, 0);

        // Reset during FLUSH aborts; a later M raise commits normally.
        advance = 1'b0;
        stageValid = 4'b1000; p_pc[3] = 32'h8000;
        raise[3] = 1'b1; raiseCause[19:15] = 5'd12;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s7_rst_flush", flush, 0);
        chk("s7_rst_isException", isException, 0);
        chk("s7_rst_cause", exceptionCause, 0);
        tick();
        chk("s7_after_isException", isException, 0);
        stageValid = 4'b1000; p_pc[3] = 32'h9000;
        raise[3] = 1'b1; raiseCause[19:15] = 5'd13; badVAddrM = 32'h55;
        tick();
        chk("s7_new_isException", isException, 1);
        chk("s7_new_cause", exceptionCause, 13);
        chk("s7_new_pc", exceptionPC, 32'h9000);
        chk("s7_new_bva", exceptionBadVAddr, 32'h55);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
